// File: rtl/wb_logic_regs.sv
// Wishbone classic slave that wraps a small logic/arithmetic unit.
// The host writes the operands and the op. RESULT and CARRY become valid one cycle after the write ack.
module wb_logic_regs #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    input  logic          wb_we_i,
    input  logic          wb_stb_i,
    input  logic          wb_cyc_i,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic [DW-1:0] result_o
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ADD  = 3'd6,
        OP_SUB  = 3'd7
    } op_e;

    localparam logic [AW-1:0] ADR_OPA    = AW'(0);
    localparam logic [AW-1:0] ADR_OPB    = AW'(1);
    localparam logic [AW-1:0] ADR_CTRL   = AW'(2);
    localparam logic [AW-1:0] ADR_RESULT = AW'(3);
    localparam logic [AW-1:0] ADR_STATUS = AW'(4);
    localparam logic [AW-1:0] ADR_WCOUNT = AW'(5);

    logic [DW-1:0] r_opa;
    logic [DW-1:0] r_opb;
    logic [DW-1:0] r_result;
    logic [DW-1:0] r_wcount;
    logic [DW-1:0] r_dat;
    op_e           r_op;
    logic          r_busy;
    logic          r_carry;
    logic          r_ack;
    logic          r_err;

    logic          w_req;
    logic          w_err;
    logic [DW-1:0] w_rdata;
    logic [DW:0]   w_alu;

    // A new request can only be sampled once the previous response pulse has ended.
    assign w_req = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_err = (wb_adr_i > ADR_WCOUNT) |
                   (wb_we_i & ((wb_adr_i == ADR_RESULT) | (wb_adr_i == ADR_STATUS)));

    always_comb begin
        // NOTE: assign a default first so that no path leaves the signal unassigned. An unassigned path would infer a latch.
        w_rdata = '0;
        case (wb_adr_i)
            ADR_OPA:    w_rdata = r_opa;
            ADR_OPB:    w_rdata = r_opb;
            ADR_CTRL:   w_rdata = {{(DW-3){1'b0}}, r_op};
            ADR_RESULT: w_rdata = r_result;
            ADR_STATUS: w_rdata = {{(DW-2){1'b0}}, r_carry, r_busy};
            ADR_WCOUNT: w_rdata = r_wcount;
            default:    w_rdata = '0;
        endcase
    end

    // Bit DW holds the carry-out for ADD and the borrow (A < B) for SUB.
    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_AND:  w_alu = {1'b0, r_opa & r_opb};
            OP_OR:   w_alu = {1'b0, r_opa | r_opb};
            OP_XOR:  w_alu = {1'b0, r_opa ^ r_opb};
            OP_NAND: w_alu = {1'b0, ~(r_opa & r_opb)};
            OP_NOR:  w_alu = {1'b0, ~(r_opa | r_opb)};
            OP_XNOR: w_alu = {1'b0, ~(r_opa ^ r_opb)};
            OP_ADD:  w_alu = {1'b0, r_opa} + {1'b0, r_opb};
            OP_SUB:  w_alu = {1'b0, r_opa} - {1'b0, r_opb};
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_op     <= OP_AND;
            r_result <= '0;
            r_wcount <= '0;
            r_busy   <= 1'b0;
            r_carry  <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat    <= '0;
        end else begin
            // NOTE: use non-blocking assignments for all state. Every register then sees the values from before the edge.
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;

            if (r_busy) begin
                r_result <= w_alu[DW-1:0];
                r_carry  <= w_alu[DW];
                r_busy   <= 1'b0;
            end

            // A commit and a busy cycle never coincide: the ack that follows every commit blocks the next request.
            if (w_req) begin
                if (w_err) begin
                    r_err <= 1'b1;
                end else begin
                    r_ack <= 1'b1;
                    if (!wb_we_i) begin
                        r_dat <= w_rdata;
                    end else begin
                        case (wb_adr_i)
                            ADR_OPA:    r_opa    <= wb_dat_i;
                            ADR_OPB:    r_opb    <= wb_dat_i;
                            ADR_CTRL:   r_op     <= op_e'(wb_dat_i[2:0]);
                            ADR_WCOUNT: r_wcount <= '0;
                            default:    ;
                        endcase
                        if (wb_adr_i <= ADR_CTRL) begin
                            r_busy   <= 1'b1;
                            r_wcount <= r_wcount + DW'(1);
                        end
                    end
                end
            end
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_dat_o = r_dat;
    assign result_o = r_result;

endmodule
